// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: gathers operand A, operand B and an opcode from a byte
// stream, holds them on the ALU inputs for one evaluation cycle, then returns
// the ALU result (or an illegal-opcode flag) over a result port.
//
// Handshake semantics (both ports): a transfer happens on a rising clk edge
// where valid && ready. A source holds its data and valid until that transfer.
// in_ready depends only on state; res_valid is high for the whole SEND state.
// res_data and res_err are held stable while res_valid is high.
module alu_op_sequencer #(
  parameter int N_BITS  = 8,
  parameter int OP_BITS = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_BITS-1:0]  in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [N_BITS-1:0]  alu_d0,
  output logic [N_BITS-1:0]  alu_d1,
  output logic [OP_BITS-1:0] alu_opcode,
  input  logic [N_BITS-1:0]  alu_out,
  output logic [N_BITS-1:0]  res_data,
  output logic               res_err,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [2:0]         dbg_state
);

  typedef enum logic [2:0] {
    GET_A  = 3'd0,
    GET_B  = 3'd1,
    GET_OP = 3'd2,
    EXEC   = 3'd3,
    SEND   = 3'd4
  } state_t;

  localparam logic [OP_BITS-1:0] OP_ADD = OP_BITS'(6'b100000);
  localparam logic [OP_BITS-1:0] OP_SUB = OP_BITS'(6'b100010);
  localparam logic [OP_BITS-1:0] OP_AND = OP_BITS'(6'b100100);
  localparam logic [OP_BITS-1:0] OP_OR  = OP_BITS'(6'b100101);
  localparam logic [OP_BITS-1:0] OP_XOR = OP_BITS'(6'b100110);
  localparam logic [OP_BITS-1:0] OP_SRA = OP_BITS'(6'b000011);
  localparam logic [OP_BITS-1:0] OP_SRL = OP_BITS'(6'b000010);
  localparam logic [OP_BITS-1:0] OP_NOR = OP_BITS'(6'b100111);

  state_t state;
  state_t state_nxt;
  logic   in_fire;
  logic   res_fire;
  logic   byte_legal;
  logic   op_legal;

  assign in_fire  = in_valid && in_ready;
  assign res_fire = res_valid && res_ready;

  // Legality of the incoming byte when interpreted as an opcode: unused upper
  // bits must be clear and the low bits must name a supported operation.
  always_comb begin
    byte_legal = 1'b0;
    if ((in_data >> OP_BITS) == '0) begin
      case (in_data[OP_BITS-1:0])
        OP_ADD, OP_SUB, OP_AND, OP_OR,
        OP_XOR, OP_SRA, OP_SRL, OP_NOR: byte_legal = 1'b1;
        default:                        byte_legal = 1'b0;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= GET_A;
    else       state <= state_nxt;
  end

  // Next-state: the three collect states advance on an input transfer, EXEC
  // always lasts one cycle, SEND waits for the consumer.
  always_comb begin
    state_nxt = state;
    case (state)
      GET_A:   if (in_fire)  state_nxt = GET_B;
      GET_B:   if (in_fire)  state_nxt = GET_OP;
      GET_OP:  if (in_fire)  state_nxt = EXEC;
      EXEC:                  state_nxt = SEND;
      SEND:    if (res_fire) state_nxt = GET_A;
      default:               state_nxt = GET_A;
    endcase
  end

  // Outputs decoded from state only.
  always_comb begin
    in_ready  = (state == GET_A) || (state == GET_B) || (state == GET_OP);
    res_valid = (state == SEND);
    dbg_state = state;
  end

  // Held ALU inputs: each register loads on the transfer of its own byte and
  // otherwise keeps its value, including across the end of a transaction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_d0     <= '0;
      alu_d1     <= '0;
      alu_opcode <= '0;
      op_legal   <= 1'b0;
    end else if (in_fire) begin
      case (state)
        GET_A:   alu_d0 <= in_data;
        GET_B:   alu_d1 <= in_data;
        GET_OP: begin
          alu_opcode <= in_data[OP_BITS-1:0];
          op_legal   <= byte_legal;
        end
        default: ;
      endcase
    end
  end

  // Result capture at the end of EXEC; the ALU has had a full cycle to settle
  // from the held registers. An illegal opcode reports zero with the error bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      res_data <= '0;
      res_err  <= 1'b0;
    end else if (state == EXEC) begin
      res_data <= op_legal ? alu_out : '0;
      res_err  <= ~op_legal;
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: supplies a behavioural ALU on alu_out, drives
// directed and random transactions, and checks every cycle against a
// transaction-level model of the byte stream and result queue.
module tb_alu_op_sequencer;

  localparam int W   = 8;
  localparam int OPW = 6;

  // ---------------- clock / reset ----------------
  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [W-1:0]   in_data = '0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [W-1:0]   alu_d0;
  logic [W-1:0]   alu_d1;
  logic [OPW-1:0] alu_opcode;
  logic [W-1:0]   alu_out;
  logic [W-1:0]   res_data;
  logic           res_err;
  logic           res_valid;
  logic           res_ready = 1'b1;
  logic [2:0]     dbg_state;

  always #5 clk = ~clk;

  alu_op_sequencer #(.N_BITS(W), .OP_BITS(OPW)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .alu_d0     (alu_d0),
    .alu_d1     (alu_d1),
    .alu_opcode (alu_opcode),
    .alu_out    (alu_out),
    .res_data   (res_data),
    .res_err    (res_err),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .dbg_state  (dbg_state)
  );

  // ---------------- ALU and legality rules ----------------
  function automatic logic [W-1:0] alu_fn(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [OPW-1:0] op);
    case (op)
      6'h20:   return a + b;
      6'h22:   return a - b;
      6'h24:   return a & b;
      6'h25:   return a | b;
      6'h26:   return a ^ b;
      6'h03:   return W'($signed(a) >>> b);
      6'h02:   return a >> b;
      6'h27:   return ~(a | b);
      default: return '0;
    endcase
  endfunction

  function automatic logic legal_fn(input logic [W-1:0] opb);
    logic [OPW-1:0] lo;
    lo = opb[OPW-1:0];
    return (opb[W-1:OPW] == '0) &&
           (lo inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h03, 6'h02, 6'h27});
  endfunction

  assign alu_out = alu_fn(alu_d0, alu_d1, alu_opcode);

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;

  logic [W-1:0] exp_q[$];
  logic         exp_err_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: bytes collected so far, a result owed to the consumer,
  // and the cycle index from which that result must be visible.
  int             nb = 0;
  logic           owed = 1'b0;
  int             negs = 0;
  int             valid_from = 0;
  logic [W-1:0]   m_d0 = '0;
  logic [W-1:0]   m_d1 = '0;
  logic [OPW-1:0] m_op = '0;
  int             n_res = 0;
  logic [W-1:0]   last_data = '0;
  logic           last_err = 1'b0;
  int             op_neg = 0;
  int             rv_neg = 0;
  logic           rv_prev = 1'b0;

  // Compare process: every falling edge, check DUT outputs against the model,
  // then advance the model for the transfer the next rising edge will make.
  always @(negedge clk) begin
    logic exp_rv;
    logic [W-1:0] r;
    if (reset) begin
      nb = 0;
      owed = 1'b0;
      exp_q.delete();
      exp_err_q.delete();
      m_d0 = '0;
      m_d1 = '0;
      m_op = '0;
      rv_prev = 1'b0;
    end else begin
      negs++;
      exp_rv = owed && (negs >= valid_from);
      chk("in_ready", in_ready, !owed);
      chk("res_valid", res_valid, exp_rv);
      chk("alu_d0", alu_d0, m_d0);
      chk("alu_d1", alu_d1, m_d1);
      chk("alu_opcode", alu_opcode, m_op);
      if (exp_rv) begin
        chk("res_data", res_data, exp_q[0]);
        chk("res_err", res_err, exp_err_q[0]);
      end
      if (res_valid && !rv_prev) rv_neg = negs;
      rv_prev = res_valid;
      if (exp_rv && res_ready) begin
        last_data = res_data;
        last_err  = res_err;
        void'(exp_q.pop_front());
        void'(exp_err_q.pop_front());
        owed = 1'b0;
        n_res++;
      end else if (!owed && in_valid) begin
        if (nb == 0) begin
          m_d0 = in_data;
          nb = 1;
        end else if (nb == 1) begin
          m_d1 = in_data;
          nb = 2;
        end else begin
          m_op = in_data[OPW-1:0];
          r = legal_fn(in_data) ? alu_fn(m_d0, m_d1, in_data[OPW-1:0]) : '0;
          exp_q.push_back(r);
          exp_err_q.push_back(!legal_fn(in_data));
          owed = 1'b1;
          valid_from = negs + 2;
          op_neg = negs;
          nb = 0;
        end
      end
    end
  end

  // Random consumer backpressure when enabled.
  logic rand_rr = 1'b0;
  always @(posedge clk) begin
    if (rand_rr) begin
      #1;
      res_ready = 1'($urandom_range(0, 1));
    end
  end

  // ---------------- driver tasks (start/end at posedge+1) ----------------
  task automatic send_byte(input logic [W-1:0] b, input int gap);
    bit ok;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    in_data  = b;
    in_valid = 1'b1;
    ok = 1'b0;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    chk("in_accept_timeout", ok, 1'b1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_txn(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] op, input int gap);
    send_byte(a, gap);
    send_byte(b, gap);
    send_byte(op, gap);
  endtask

  task automatic wait_result(input int target);
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 3000; t++) begin
      if (n_res >= target) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    chk("result_timeout", ok, 1'b1);
  endtask

  task automatic txn_expect(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [W-1:0] op, input logic [W-1:0] d, input logic e);
    int target;
    target = n_res + 1;
    send_txn(a, b, op, 0);
    wait_result(target);
    chk({name, "_data"}, last_data, d);
    chk({name, "_err"}, last_err, e);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  logic [W-1:0] legal_ops[8] = '{8'h20, 8'h22, 8'h24, 8'h25, 8'h26, 8'h03, 8'h02, 8'h27};

  initial begin
    int target;
    int base;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic [W-1:0] rop;

    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Reset state.
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_res_valid", res_valid, 1'b0);
    chk("rst_res_data", res_data, 8'h00);
    chk("rst_res_err", res_err, 1'b0);
    chk("rst_alu_d0", alu_d0, 8'h00);
    chk("rst_alu_opcode", alu_opcode, 6'h00);

    // ADD with latency pin.
    txn_expect("add", 8'd100, 8'd27, 8'h20, 8'h7F, 1'b0);
    chk("add_latency", rv_neg - op_neg, 2);

    // SUB wrap, SRA.
    txn_expect("sub", 8'd5, 8'd10, 8'h22, 8'hFB, 1'b0);
    txn_expect("sra", 8'h80, 8'd3, 8'h03, 8'hF0, 1'b0);

    // Illegal opcodes then a legal ADD.
    txn_expect("ill_3f", 8'd7, 8'd3, 8'h3F, 8'h00, 1'b1);
    txn_expect("ill_60", 8'd7, 8'd3, 8'h60, 8'h00, 1'b1);
    txn_expect("add_after_ill", 8'd1, 8'd1, 8'h20, 8'h02, 1'b0);

    // Backpressure: result held with a new byte waiting.
    res_ready = 1'b0;
    target = n_res + 1;
    send_txn(8'h0C, 8'h0A, 8'h24, 0);
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (res_valid) break;
    end
    @(posedge clk);
    #1;
    in_data  = 8'h11;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_in_ready", in_ready, 1'b0);
      chk("bp_res_valid", res_valid, 1'b1);
      chk("bp_res_data", res_data, 8'h08);
      chk("bp_res_err", res_err, 1'b0);
    end
    @(posedge clk);
    #1;
    res_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_release_in_ready", in_ready, 1'b1);
    chk("bp_result_count", n_res, target);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    target = n_res + 1;
    send_byte(8'h01, 0);
    send_byte(8'h20, 0);
    wait_result(target);
    chk("bp_next_data", last_data, 8'h12);

    // Input gaps between A and B.
    target = n_res + 1;
    send_byte(8'h0F, 0);
    send_byte(8'hF0, 3);
    send_byte(8'h25, 0);
    wait_result(target);
    chk("gap_or_data", last_data, 8'hFF);
    chk("gap_or_err", last_err, 1'b0);

    // Asynchronous reset after A and B accepted.
    send_byte(8'h44, 0);
    send_byte(8'h55, 0);
    #3;
    reset = 1'b1;
    #1;
    chk("arst_alu_d0", alu_d0, 8'h00);
    chk("arst_alu_d1", alu_d1, 8'h00);
    chk("arst_res_valid", res_valid, 1'b0);
    chk("arst_res_data", res_data, 8'h00);
    @(posedge clk);
    #2;
    reset = 1'b0;
    @(posedge clk);
    #1;
    base = n_res;
    txn_expect("post_rst_add", 8'd2, 8'd3, 8'h20, 8'h05, 1'b0);
    chk("post_rst_count", n_res, base + 1);

    // Random transactions with random gaps and backpressure.
    rand_rr = 1'b1;
    base = n_res;
    for (int i = 0; i < 200; i++) begin
      ra = W'($urandom_range(0, 255));
      rb = W'($urandom_range(0, 255));
      if ($urandom_range(0, 3) == 0) rop = W'($urandom_range(0, 255));
      else rop = legal_ops[$urandom_range(0, 7)];
      send_txn(ra, rb, rop, $urandom_range(0, 2));
    end
    wait_result(base + 200);
    rand_rr = 1'b0;
    @(posedge clk);
    #1;
    res_ready = 1'b1;
    repeat (3) @(posedge clk);
    chk("final_queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
